// File: rtl/bp_cfg_link_pkg.sv
// Shared cfg-link constants, write payload and boot-loader state encoding.
package bp_cfg_link_pkg;

    localparam int unsigned bp_cfg_link_addr_width_gp = 16;
    localparam int unsigned bp_cfg_link_data_width_gp = 32;
    localparam int unsigned bp_cfg_ucode_idx_width_gp = 12;
    localparam int unsigned bp_cfg_ucode_max_els_gp   = 4096;

    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_freeze_gp      = 16'h0002;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_start_pc_lo_gp = 16'h0040;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_start_pc_hi_gp = 16'h0041;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_cce_mode_gp    = 16'h0060;
    localparam logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_reg_ucode_base_gp  = 16'h8000;

    typedef struct packed {
        logic [bp_cfg_link_addr_width_gp-1:0] addr;
        logic [bp_cfg_link_data_width_gp-1:0] data;
    } bp_cfg_write_s;

    typedef enum logic [3:0] {
        e_idle,
        e_frz_on,
        e_pc_lo,
        e_pc_hi,
        e_uc_rd,
        e_uc_wr,
        e_mode,
        e_frz_off,
        e_done
    } bp_cfg_loader_state_e;

    // Ucode words map linearly into the 4K window above the ucode base.
    function automatic logic [bp_cfg_link_addr_width_gp-1:0] bp_cfg_ucode_addr(
        input logic [bp_cfg_ucode_idx_width_gp-1:0] idx
    );
        return bp_cfg_reg_ucode_base_gp | bp_cfg_link_addr_width_gp'(idx);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up-counter with synchronous clear; clear wins over up.
module bsg_counter_clear_up #(
    parameter int unsigned         width_p    = 12,
    parameter logic [width_p-1:0]  init_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= init_val_p;
        end else if (clear_i) begin
            count_o <= init_val_p;
        end else if (up_i) begin
            count_o <= count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time cfg-link initiator: freeze, start PC, ucode image, cce mode, unfreeze.
module bp_cfg_loader
    import bp_cfg_link_pkg::*;
#(
    parameter int unsigned                          cce_ucode_els_p = 256,
    parameter logic [63:0]                          start_pc_p      = 64'h0000_0000_8000_0000,
    parameter logic [bp_cfg_link_data_width_gp-1:0] cce_mode_p      = 32'h1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 start_i,
    output logic                                 cfg_v_o,
    output logic [bp_cfg_link_addr_width_gp-1:0] cfg_addr_o,
    output logic [bp_cfg_link_data_width_gp-1:0] cfg_data_o,
    input  logic                                 cfg_ready_i,
    output logic                                 ucode_r_v_o,
    output logic [bp_cfg_ucode_idx_width_gp-1:0] ucode_addr_o,
    input  logic [bp_cfg_link_data_width_gp-1:0] ucode_data_i,
    output logic                                 busy_o,
    output logic                                 done_o
);

    if (cce_ucode_els_p > bp_cfg_ucode_max_els_gp) begin : g_els_check
        $error("bp_cfg_loader: cce_ucode_els_p must not exceed 4096");
    end

    localparam logic [bp_cfg_ucode_idx_width_gp-1:0] last_idx_lp =
        (cce_ucode_els_p == 0) ? '0 : bp_cfg_ucode_idx_width_gp'(cce_ucode_els_p - 1);

    bp_cfg_loader_state_e                 state_q, state_n;
    logic [bp_cfg_ucode_idx_width_gp-1:0] uc_idx;
    logic                                 accept, start_ok, uc_last, uc_up;
    bp_cfg_write_s                        wr_n;
    logic                                 cfg_v_n, ucode_r_v_n, busy_n, done_n;
    logic                                 fwd_n, fwd_q;
    logic [bp_cfg_link_data_width_gp-1:0] data_q;

    assign accept       = cfg_v_o & cfg_ready_i;
    assign start_ok     = start_i & (state_q == e_idle);
    assign uc_last      = (uc_idx == last_idx_lp);
    assign uc_up        = (state_q == e_uc_wr) & accept;
    assign ucode_addr_o = uc_idx;

    // Ucode word index: restarts with each sequence, steps on every ucode accept.
    bsg_counter_clear_up #(
        .width_p   (bp_cfg_ucode_idx_width_gp),
        .init_val_p('0)
    ) u_uc_idx (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(start_ok),
        .up_i   (uc_up),
        .count_o(uc_idx)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            e_idle:    if (start_i) state_n = e_frz_on;
            e_frz_on:  if (accept)  state_n = e_pc_lo;
            e_pc_lo:   if (accept)  state_n = e_pc_hi;
            e_pc_hi:   if (accept)  state_n = (cce_ucode_els_p == 0) ? e_mode : e_uc_rd;
            e_uc_rd:                state_n = e_uc_wr;
            e_uc_wr:   if (accept)  state_n = uc_last ? e_mode : e_uc_rd;
            e_mode:    if (accept)  state_n = e_frz_off;
            e_frz_off: if (accept)  state_n = e_done;
            e_done:                 state_n = e_idle;
            default:                state_n = e_idle;
        endcase
    end

    // Next-cycle outputs decoded from the upcoming state, then registered below.
    always_comb begin
        wr_n        = '0;
        cfg_v_n     = 1'b0;
        ucode_r_v_n = 1'b0;
        fwd_n       = 1'b0;
        busy_n      = (state_n != e_idle);
        done_n      = start_ok ? 1'b0 : done_o;
        case (state_n)
            e_frz_on: begin
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_reg_freeze_gp;
                wr_n.data = bp_cfg_link_data_width_gp'(1);
            end
            e_pc_lo: begin
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_reg_start_pc_lo_gp;
                wr_n.data = start_pc_p[31:0];
            end
            e_pc_hi: begin
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_reg_start_pc_hi_gp;
                wr_n.data = start_pc_p[63:32];
            end
            e_uc_rd: begin
                ucode_r_v_n = 1'b1;
            end
            e_uc_wr: begin
                // ROM word arrives in the first UC_WR cycle: forward it, then hold the captured copy.
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_ucode_addr(uc_idx);
                fwd_n     = (state_q == e_uc_rd);
                wr_n.data = fwd_q ? ucode_data_i : data_q;
            end
            e_mode: begin
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_reg_cce_mode_gp;
                wr_n.data = cce_mode_p;
            end
            e_frz_off: begin
                cfg_v_n   = 1'b1;
                wr_n.addr = bp_cfg_reg_freeze_gp;
                wr_n.data = '0;
            end
            e_done: begin
                done_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cfg_v_o     <= 1'b0;
            cfg_addr_o  <= '0;
            data_q      <= '0;
            fwd_q       <= 1'b0;
            ucode_r_v_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            cfg_v_o     <= cfg_v_n;
            cfg_addr_o  <= wr_n.addr;
            data_q      <= wr_n.data;
            fwd_q       <= fwd_n;
            ucode_r_v_o <= ucode_r_v_n;
            busy_o      <= busy_n;
            done_o      <= done_n;
        end
    end

    assign cfg_data_o = fwd_q ? ucode_data_i : data_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Self-checking bench for bp_cfg_loader: three parameterisations (4, 0 and 4096 ucode words)
// checked against a write-list model, a cycle table and directed corner sequences.
module tb_bp_cfg_loader;

    localparam int NI = 3;
    localparam int          ELS  [NI] = '{4, 0, 4096};
    localparam logic [63:0] PC   [NI] = '{64'h1_8000_0000, 64'h8000_0000, 64'h8000_0000};
    localparam logic [31:0] MODE [NI] = '{32'h1, 32'h5, 32'h1};

    logic        clk = 1'b0;
    logic        reset;
    logic        start    [NI];
    logic        ready    [NI];
    logic        cfg_v    [NI];
    logic [15:0] cfg_addr [NI];
    logic [31:0] cfg_data [NI];
    logic        rv       [NI];
    logic [11:0] raddr    [NI];
    logic [31:0] rom_data [NI];
    logic        busy     [NI];
    logic        done     [NI];

    always #5 clk = ~clk;

    bp_cfg_loader #(.cce_ucode_els_p(ELS[0]), .start_pc_p(PC[0]), .cce_mode_p(MODE[0])) u_dut4 (
        .clk_i(clk), .reset_i(reset), .start_i(start[0]),
        .cfg_v_o(cfg_v[0]), .cfg_addr_o(cfg_addr[0]), .cfg_data_o(cfg_data[0]), .cfg_ready_i(ready[0]),
        .ucode_r_v_o(rv[0]), .ucode_addr_o(raddr[0]), .ucode_data_i(rom_data[0]),
        .busy_o(busy[0]), .done_o(done[0]));

    bp_cfg_loader #(.cce_ucode_els_p(ELS[1]), .start_pc_p(PC[1]), .cce_mode_p(MODE[1])) u_dut0 (
        .clk_i(clk), .reset_i(reset), .start_i(start[1]),
        .cfg_v_o(cfg_v[1]), .cfg_addr_o(cfg_addr[1]), .cfg_data_o(cfg_data[1]), .cfg_ready_i(ready[1]),
        .ucode_r_v_o(rv[1]), .ucode_addr_o(raddr[1]), .ucode_data_i(rom_data[1]),
        .busy_o(busy[1]), .done_o(done[1]));

    bp_cfg_loader #(.cce_ucode_els_p(ELS[2]), .start_pc_p(PC[2]), .cce_mode_p(MODE[2])) u_dut4k (
        .clk_i(clk), .reset_i(reset), .start_i(start[2]),
        .cfg_v_o(cfg_v[2]), .cfg_addr_o(cfg_addr[2]), .cfg_data_o(cfg_data[2]), .cfg_ready_i(ready[2]),
        .ucode_r_v_o(rv[2]), .ucode_addr_o(raddr[2]), .ucode_data_i(rom_data[2]),
        .busy_o(busy[2]), .done_o(done[2]));

    function automatic logic [31:0] rom_word(input int i);
        return 32'hA0 + 32'(i);
    endfunction

    // ROM model: data for a read strobe appears the next cycle; otherwise the bus carries junk.
    logic        rv_s [NI];
    logic [11:0] ra_s [NI];
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++)
            rom_data[k] <= rv_s[k] ? rom_word(int'(ra_s[k])) : $urandom();
    end

    // Link monitor: accepted writes, hold violations under stall, done pulses, ROM reads.
    logic [47:0] obs [NI][$];
    int   rises      [NI] = '{default: 0};
    int   stall_viol [NI] = '{default: 0};
    int   rd_cnt     [NI] = '{default: 0};
    logic        pv [NI] = '{default: 1'b0};
    logic        pr [NI];
    logic        pd [NI] = '{default: 1'b0};
    logic [15:0] pa [NI];
    logic [31:0] pdt[NI];
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            rv_s[k] = rv[k];
            ra_s[k] = raddr[k];
            if (!reset) begin
                if (cfg_v[k] && ready[k]) obs[k].push_back({cfg_addr[k], cfg_data[k]});
                if (pv[k] && !pr[k] && !(cfg_v[k] && cfg_addr[k] == pa[k] && cfg_data[k] == pdt[k]))
                    stall_viol[k]++;
                if (done[k] && !pd[k]) rises[k]++;
                if (rv[k]) rd_cnt[k]++;
            end
            pv[k]  = cfg_v[k] && !reset;
            pr[k]  = ready[k];
            pa[k]  = cfg_addr[k];
            pdt[k] = cfg_data[k];
            pd[k]  = done[k];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference write list, built directly from the boot sequence definition.
    logic [47:0] exp_q[$];
    task automatic build_exp(input int k);
        logic [63:0] pc;
        pc = PC[k];
        exp_q.delete();
        exp_q.push_back({16'h0002, 32'h1});
        exp_q.push_back({16'h0040, pc[31:0]});
        exp_q.push_back({16'h0041, pc[63:32]});
        for (int i = 0; i < ELS[k]; i++) exp_q.push_back({16'h8000 + 16'(i), rom_word(i)});
        exp_q.push_back({16'h0060, MODE[k]});
        exp_q.push_back({16'h0002, 32'h0});
    endtask

    task automatic cmp_writes(input string tag, input int k, input int base);
        int bad;
        build_exp(k);
        check_eq({tag, " nwrites"}, longint'(obs[k].size() - base), longint'(exp_q.size()));
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (base + i >= obs[k].size() || obs[k][base + i] != exp_q[i])) bad = i;
        check_eq({tag, " first_bad_write_idx"}, longint'(bad), -1);
        if (bad >= 0 && base + bad < obs[k].size())
            $display("  %s write %0d got %h want %h", tag, bad, obs[k][base + bad], exp_q[bad]);
    endtask

    // Pulse start, optionally randomise ready and re-pulse start at cycle restart_at; lat=0 on timeout.
    task automatic run_seq(input int k, input bit rnd, input int restart_at, input int budget,
                           output int lat);
        start[k] = 1'b1;
        ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        step();
        start[k] = 1'b0;
        lat = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (done[k]) begin
                lat = c;
                break;
            end
            step();
            start[k] = (c + 1 == restart_at);
            if (rnd) ready[k] = 1'($urandom_range(0, 1));
        end
        step();
        start[k] = 1'b0;
        ready[k] = 1'b1;
    endtask

    function automatic logic [63:0] pack(input logic v, input logic r, input logic b, input logic d,
                                         input logic [15:0] a, input logic [31:0] dt,
                                         input logic [11:0] ra);
        return {v, r, b, d, v ? a : 16'h0, v ? dt : 32'h0, r ? ra : 12'h0};
    endfunction

    typedef struct {
        bit          ready;
        bit          v;
        bit          rv;
        bit          busy;
        bit          done;
        logic [15:0] addr;
        logic [31:0] data;
        logic [11:0] raddr;
    } vec_t;
    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base, r0, s0, d0, lat;
        bit found;

        // els=4, PC=1_8000_0000, one stall on the first ucode write (ROM junk afterwards).
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 32'h1,         12'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 32'h8000_0000, 12'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0041, 32'h1,         12'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,         12'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 32'hA0,        12'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8000, 32'hA0,        12'h0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,         12'h1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8001, 32'hA1,        12'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,         12'h2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8002, 32'hA2,        12'h0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h0,         12'h3};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h8003, 32'hA3,        12'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0060, 32'h1,         12'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 32'h0,         12'h0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 32'h0,         12'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0,         12'h0};

        reset = 1'b1;
        for (int k = 0; k < NI; k++) begin
            start[k] = 1'b0;
            ready[k] = 1'b1;
        end
        repeat (3) step();
        @(negedge clk);
        for (int k = 0; k < NI; k++)
            check_eq($sformatf("reset_state[%0d]", k),
                     longint'({cfg_v[k], rv[k], busy[k], done[k], cfg_addr[k], cfg_data[k], raddr[k]}), 0);
        step();
        reset = 1'b0;
        step();

        // Cycle-by-cycle table on the 4-word loader.
        base = obs[0].size();
        r0   = rises[0];
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ready[0] = tbl[i].ready;
            @(negedge clk);
            check_eq($sformatf("table cycle %0d", i + 1),
                     longint'(pack(cfg_v[0], rv[0], busy[0], done[0], cfg_addr[0], cfg_data[0], raddr[0])),
                     longint'(pack(tbl[i].v, tbl[i].rv, tbl[i].busy, tbl[i].done,
                                   tbl[i].addr, tbl[i].data, tbl[i].raddr)));
            step();
        end
        ready[0] = 1'b1;
        cmp_writes("table", 0, base);
        check_eq("table done pulses", rises[0] - r0, 1);

        // Random backpressure: same write list, stable while stalled, one done per run.
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 3)) step();
            base = obs[0].size();
            r0   = rises[0];
            s0   = stall_viol[0];
            run_seq(0, 1'b1, 0, 400, lat);
            check_eq($sformatf("rnd%0d completed", r), longint'(lat > 0), 1);
            cmp_writes($sformatf("rnd%0d", r), 0, base);
            check_eq($sformatf("rnd%0d done pulses", r), rises[0] - r0, 1);
            check_eq($sformatf("rnd%0d stall hold violations", r), stall_viol[0] - s0, 0);
        end

        // Empty ucode image: five writes, no ROM traffic, 6-cycle latency.
        base = obs[1].size();
        d0   = rd_cnt[1];
        run_seq(1, 1'b0, 0, 50, lat);
        check_eq("els0 latency", lat, 6);
        cmp_writes("els0", 1, base);
        check_eq("els0 rom reads", rd_cnt[1] - d0, 0);

        // Second start while busy is ignored.
        base = obs[0].size();
        r0   = rises[0];
        run_seq(0, 1'b0, 3, 100, lat);
        check_eq("restart@3 latency", lat, 14);
        cmp_writes("restart@3", 0, base);
        check_eq("restart@3 done pulses", rises[0] - r0, 1);

        // Start in the DONE cycle is ignored.
        run_seq(0, 1'b0, 14, 100, lat);
        check_eq("start@done latency", lat, 14);
        @(negedge clk);
        check_eq("start@done ignored busy", longint'(busy[0]), 0);
        step();

        // Reset while the second ucode word is on the link, then full replay.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rv[0] && raddr[0] == 12'd1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check_eq("reset test reached ucode 1", longint'(found), 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check_eq("after mid reset v/busy/done", longint'({cfg_v[0], busy[0], done[0]}), 0);
        step();
        base = obs[0].size();
        run_seq(0, 1'b0, 0, 100, lat);
        check_eq("replay latency", lat, 14);
        cmp_writes("replay", 0, base);

        // Full 4096-word image: last ucode write lands on 0x8fff, then cce_mode.
        base = obs[2].size();
        run_seq(2, 1'b0, 0, 9000, lat);
        check_eq("els4096 latency", lat, 8198);
        cmp_writes("els4096", 2, base);
        check_eq("els4096 last ucode addr",
                 (obs[2].size() > base + 4099) ? longint'(obs[2][base + 4098][47:32]) : -1, 16'h8fff);
        check_eq("els4096 write after last ucode",
                 (obs[2].size() > base + 4099) ? longint'(obs[2][base + 4099][47:32]) : -1, 16'h0060);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
